// File: rtl/mod12_cmd_ctrl.sv
// Round-robin command controller for a mod-MODULUS up/down counter.
// Sequences load/mode/data_in per command and checks data_out against a shadow count.
module mod12_cmd_ctrl #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req0_arg,
    input  logic [WIDTH-1:0] req1_arg,
    output logic             load,
    output logic             mode,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             err,
    output logic             mismatch,
    output logic             mismatch_sticky
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CHECK} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_t;

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic             sticky_q, sticky_d;

    logic             both_valid, grant0, grant1;
    logic             arg_legal;
    logic [WIDTH-1:0] shd_inc, shd_dec;

    // ptr_q holds the last granted requester; on a tie the other one wins.
    assign both_valid = req0_valid & req1_valid;
    assign grant0     = both_valid ? ptr_q  : req0_valid;
    assign grant1     = both_valid ? ~ptr_q : req1_valid;

    assign arg_legal = ({1'b0, arg_q} < MOD_W);
    assign shd_inc   = (shd_q == MAX_V) ? '0 : shd_q + WIDTH'(1);
    assign shd_dec   = (shd_q == '0) ? MAX_V : shd_q - WIDTH'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_HOLD;
            shd_q    <= '0;
            rem_q    <= '0;
            arg_q    <= '0;
            ptr_q    <= 1'b1;
            id_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            shd_q    <= shd_d;
            rem_q    <= rem_d;
            arg_q    <= arg_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        shd_d    = shd_q;
        rem_d    = rem_q;
        arg_d    = arg_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        sticky_d = sticky_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0_valid | req1_valid) begin
                    id_d    = grant1;
                    ptr_d   = grant1;
                    op_d    = grant1 ? op_t'(req1_op) : op_t'(req0_op);
                    arg_d   = grant1 ? req1_arg : req0_arg;
                    rem_d   = arg_d;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_LOAD: if (arg_legal) shd_d = arg_q;
                    OP_UP:   if (rem_q != '0) shd_d = shd_inc;
                    OP_DOWN: if (rem_q != '0) shd_d = shd_dec;
                    default: ;
                endcase
                // A zero count still spends one EXEC cycle, hence <= 1.
                if (op_q == OP_LOAD || rem_q <= WIDTH'(1)) begin
                    rem_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    rem_d = rem_q - WIDTH'(1);
                end
            end
            S_CHECK: begin
                sticky_d = sticky_q | mismatch;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load       = 1'b1;
        mode       = 1'b0;
        data_in    = shd_q;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_CHECK);
        done_id    = id_q;
        err        = done & (op_q == OP_LOAD) & ~arg_legal;
        mismatch   = done & (data_out != shd_q);
        req0_ready = (state_q == S_IDLE) & ~reset & grant0;
        req1_ready = (state_q == S_IDLE) & ~reset & grant1;
        mismatch_sticky = sticky_q | mismatch;
        if (state_q == S_EXEC) begin
            unique case (op_q)
                OP_LOAD: if (arg_legal) data_in = arg_q;
                OP_UP: begin
                    if (rem_q != '0) begin
                        load = 1'b0;
                        mode = 1'b1;
                    end
                end
                OP_DOWN: if (rem_q != '0) load = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mod12_cmd_ctrl.md
# mod12_cmd_ctrl

Command controller for the mod-12 up/down counter. It arbitrates round-robin between two requesters, each issuing LOAD / RUN_UP / RUN_DOWN / HOLD commands. It sequences the counter's `load`, `mode` and `data_in` pins cycle by cycle and keeps a shadow model of the count. After every command it checks `data_out` against the shadow and reports completion, errors and mismatches.

## Interface
Parameters:
- `MODULUS`, 12: counter modulus; legal values are 0..MODULUS-1.
- `WIDTH`, 4: width of counter data and command argument.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; also drives the counter's reset.
- `req0_valid`, `req1_valid`  in  1  command present from requester 0/1.
- `req0_ready`, `req1_ready`  out  1  command accepted at this posedge if valid.
- `req0_op`, `req1_op`  in  2  00 LOAD, 01 RUN_UP, 10 RUN_DOWN, 11 HOLD.
- `req0_arg`, `req1_arg`  in  WIDTH  LOAD value, or cycle count n for RUN/HOLD.
- `load`  out  1  to counter; 1 = load `data_in` at next posedge.
- `mode`  out  1  to counter; 1 = count up, 0 = count down.
- `data_in`  out  WIDTH  to counter.
- `data_out`  in  WIDTH  from counter (registered count).
- `busy`  out  1  command in progress (state ≠ IDLE).
- `done`  out  1  one-cycle completion strobe.
- `done_id`  out  1  requester of the completed command; valid with `done`.
- `err`  out  1  with `done`: command was illegal (LOAD arg ≥ MODULUS).
- `mismatch`  out  1  with `done`: `data_out` ≠ shadow.
- `mismatch_sticky`  out  1  set on any mismatch; cleared only by `reset`.

## Operation
- Counter model:
  - `load`=1: count ← `data_in`.
  - `load`=0, `mode`=1: count ← count+1; 11 wraps to 0.
  - `load`=0, `mode`=0: count ← count−1; 0 wraps to 11.
- Shadow register `shd` tracks the expected count. All arithmetic is modulo MODULUS.
- FSM states: IDLE → EXEC → CHECK → IDLE.
- IDLE:
  - Holds the counter: `load`=1, `data_in`=`shd`, `mode`=0.
  - `ready` is asserted only to the granted requester. Never both. Never outside IDLE.
  - Arbitration:
    - Only one valid: grant it.
    - Both valid: grant the requester not granted last.
    - Last-grant pointer resets to 1, so req0 wins the first tie.
  - On accept: latch op, arg and requester id; `remaining` ← arg; go to EXEC.
- EXEC: one counter action per cycle; `remaining` decrements.
  - LOAD, legal arg: 1 cycle; `load`=1, `data_in`=arg; `shd` ← arg.
  - LOAD, arg ≥ MODULUS: 1 cycle of hold outputs; `shd` unchanged; `err` flagged. `data_in` never carries an illegal value.
  - RUN_UP n: n cycles; `load`=0, `mode`=1; `shd` ← `shd`+1 each cycle.
  - RUN_DOWN n: n cycles; `load`=0, `mode`=0; `shd` ← `shd`−1 each cycle.
  - HOLD n: n cycles of hold outputs.
  - n = 0: exactly 1 cycle of hold outputs; completes with no count change.
- CHECK: 1 cycle of hold outputs.
  - `done`=1 with `done_id` and `err`.
  - `mismatch` = (`data_out` ≠ `shd`); it also sets `mismatch_sticky`.
  - Next state is IDLE.
- `load`, `mode`, `data_in`, `ready`, `done` and `busy` are decoded from registered state (Moore); no input-to-output combinational path except `ready`'s dependence on `reqX_valid`.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, `shd`=0, `remaining`=0, pointer=1.
  - `load`=1, `data_in`=0, `mode`=0.
  - `busy`=`done`=`err`=`mismatch`=`mismatch_sticky`=0; both `ready`=0 while `reset` is high.
- Accept at edge E0. Counter samples the EXEC outputs at E1..Ek.
  - k = n for RUN/HOLD with n ≥ 1; k = 1 for LOAD or n = 0.
- CHECK occupies the cycle after Ek; `done` is high in that cycle.
  - Accept to `done` = k+1 cycles.
  - Next accept no earlier than edge E(k+2); peak throughput is one command per k+2 cycles.
- Counter outputs change only on clock edges, so they are stable for a full cycle before being sampled.
- Reset mid-command: the command is dropped with no `done`; the counter is reset to 0 in step with `shd`.

## Test plan
- Reset, then req0 LOAD 5 → `ready0` for 1 cycle; `load`=1/`data_in`=5 for 1 cycle; next cycle `done`=1, `done_id`=0, `data_out`=5, `mismatch`=0.
- After LOAD 7, RUN_UP 9 → 9 cycles `load`=0/`mode`=1; `done` 10 cycles after accept; `data_out`=4 (wrap 11→0); `mismatch`=0.
- After LOAD 1, RUN_DOWN 3 → `data_out`=10 at `done`; then HOLD 4 → `load`=1/`data_in`=10 for 4 cycles, value stays 10.
- Both valid continuously from reset, each issuing HOLD 0 → grants 0,1,0,1; each `done_id` matches; the non-granted `ready` stays 0.
- LOAD 13 → `data_in` never 13; `done` with `err`=1; `data_out` unchanged. Forcing the counter to 3 while `shd`=2 → `mismatch`=1 and `mismatch_sticky` stays 1 until reset.
- Assert `reset` 3 cycles into RUN_UP 8 → outputs return to reset values immediately; no `done`; `busy`=0. After release, the next LOAD is accepted and completes normally.
